// File: rtl/uart_pkg.sv
// Shared constants for the UART packet transmitter: parity modes, FSM state
// encoding and the parity-bit helper.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    PAR   = 3'd3,
    STOP  = 3'd4
  } state_t;

  // ones_odd is the XOR of the eight data bits
  function automatic logic parity_bit(input int mode, input logic ones_odd);
    return (mode == PAR_ODD) ? ~ones_odd : ones_odd;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: emits one tick per BAUD_DIV cycles, held at zero while
// clear is high so the first period after clear is full length.
module uart_baud_tick #(
  parameter int BAUD_DIV = 5208
) (
  input  logic Clk,
  input  logic RstN,
  input  logic clear,
  output logic tick
);

  localparam int W = $clog2(BAUD_DIV);
  localparam logic [W-1:0] LAST = W'(BAUD_DIV - 1);

  if (BAUD_DIV < 2 || BAUD_DIV > 8191) begin : g_bad_baud
    $error("uart_baud_tick: BAUD_DIV must be in 2..8191");
  end

  logic [W-1:0] cnt;

  always_ff @(posedge Clk) begin
    if (!RstN || clear) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_tx_packet.sv
// Packet UART transmitter: captures NBYTES on acceptance and sends them as
// back-to-back 8-bit frames with optional parity and one or two stop bits.
module uart_tx_packet
  import uart_pkg::*;
#(
  parameter int NBYTES         = 5,
  parameter int BAUD_DIV       = 5208,
  parameter int PARITY         = 0,
  parameter int STOP_BITS      = 1,
  parameter int MSB_BYTE_FIRST = 1
) (
  input  logic                  Clk,
  input  logic                  RstN,
  input  logic                  DataEn,
  input  logic [8*NBYTES-1:0]   DataIn,
  output logic                  Ready,
  output logic                  Busy,
  output logic                  Done,
  output logic                  Tx
);

  localparam int BCW = $clog2(NBYTES + 1);
  localparam logic [BCW-1:0] LAST_BYTE = BCW'(NBYTES - 1);

  if (NBYTES < 1 || NBYTES > 16) begin : g_bad_nbytes
    $error("uart_tx_packet: NBYTES must be in 1..16");
  end
  if (PARITY != PAR_NONE && PARITY != PAR_ODD && PARITY != PAR_EVEN) begin : g_bad_parity
    $error("uart_tx_packet: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
    $error("uart_tx_packet: STOP_BITS must be 1 or 2");
  end
  if (MSB_BYTE_FIRST != 0 && MSB_BYTE_FIRST != 1) begin : g_bad_order
    $error("uart_tx_packet: MSB_BYTE_FIRST must be 0 or 1");
  end

  state_t              state, state_next;
  logic                tick, baud_clear;
  logic                last_bit, stop_end, pkt_end;
  logic                tx_next;
  logic [2:0]          bit_cnt;
  logic                stop_cnt;
  logic [BCW-1:0]      byte_cnt;
  logic [8*NBYTES-1:0] shift_q;
  logic                par_acc;
  logic                done_q;

  // Bytes are reordered at capture so the byte sent first sits in [7:0];
  // the buffer then simply shifts right one bit per data bit.
  function automatic logic [8*NBYTES-1:0] order(input logic [8*NBYTES-1:0] d);
    logic [8*NBYTES-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < NBYTES; i++) begin
      r[8*i +: 8] = (MSB_BYTE_FIRST != 0) ? d[8*(NBYTES-1-i) +: 8] : d[8*i +: 8];
    end
    return r;
  endfunction

  assign baud_clear = (state == IDLE);

  uart_baud_tick #(.BAUD_DIV(BAUD_DIV)) u_baud (
    .Clk   (Clk),
    .RstN  (RstN),
    .clear (baud_clear),
    .tick  (tick)
  );

  assign last_bit = tick && (bit_cnt == 3'd7);
  assign stop_end = tick && ((STOP_BITS == 1) || stop_cnt);
  assign pkt_end  = (state == STOP) && stop_end && (byte_cnt == LAST_BYTE);

  always_ff @(posedge Clk) begin
    if (!RstN) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (DataEn) state_next = START;
      START:   if (tick) state_next = DATA;
      DATA:    if (last_bit) state_next = (PARITY != PAR_NONE) ? PAR : STOP;
      PAR:     if (tick) state_next = STOP;
      STOP:    if (stop_end) state_next = (byte_cnt == LAST_BYTE) ? IDLE : START;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    Ready   = (state == IDLE);
    Busy    = (state != IDLE);
    Done    = done_q;
    tx_next = 1'b1;
    case (state)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shift_q[0];
      PAR:     tx_next = parity_bit(PARITY, par_acc);
      default: tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!RstN) begin
      Tx       <= 1'b1;
      done_q   <= 1'b0;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
      byte_cnt <= '0;
      shift_q  <= '0;
      par_acc  <= 1'b0;
    end else begin
      Tx     <= tx_next;
      done_q <= pkt_end;
      case (state)
        IDLE: begin
          if (DataEn) begin
            shift_q <= order(DataIn);
            par_acc <= 1'b0;
          end
        end
        DATA: begin
          if (tick) begin
            par_acc <= par_acc ^ shift_q[0];
            shift_q <= shift_q >> 1;
            bit_cnt <= (bit_cnt == 3'd7) ? 3'd0 : bit_cnt + 3'd1;
          end
        end
        STOP: begin
          if (stop_end) begin
            stop_cnt <= 1'b0;
            par_acc  <= 1'b0;
            byte_cnt <= (byte_cnt == LAST_BYTE) ? '0 : byte_cnt + 1'b1;
          end else if (tick) begin
            stop_cnt <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_packet.sv
// Scoreboard bench: several DUT configurations run in parallel, each with a
// frame-level reference model, a serial-line monitor and a control checker.
module tb_uart_tx_packet;

  localparam int NCFG = 6;

  typedef struct {
    int           acc;
    logic [191:0] bits;
    int           nbits;
  } pkt_t;

  //                      cfg:   0     1  2  3     4   5
  function automatic int cfg_nb(input int i);
    case (i) 0: return 5; 1: return 1; 2: return 1; 3: return 2; 4: return 1; default: return 16; endcase
  endfunction
  function automatic int cfg_bd(input int i);
    case (i) 4: return 5208; 5: return 2; default: return 4; endcase
  endfunction
  function automatic int cfg_par(input int i);
    case (i) 1: return 1; 2: return 2; 5: return 2; default: return 0; endcase
  endfunction
  function automatic int cfg_sb(input int i);
    case (i) 3: return 2; 5: return 2; default: return 1; endcase
  endfunction
  function automatic int cfg_mf(input int i);
    case (i) 3: return 0; 5: return 0; default: return 1; endcase
  endfunction
  function automatic logic [127:0] cfg_dir(input int i);
    case (i)
      0:       return 128'h80_FF_01_AA_55;
      1, 2:    return 128'h07;
      3:       return 128'h1234;
      4:       return 128'hA5;
      default: return 128'h0123456789ABCDEF_FEDCBA9876543210;
    endcase
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;
  int blocks_done = 0;

  task automatic check(input int cfg, input string what, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL cfg%0d %s: got %0h, required %0h", cfg, what, got, exp);
    end
  endtask

  for (genvar g = 0; g < NCFG; g++) begin : cfg
    localparam int NB  = cfg_nb(g);
    localparam int BD  = cfg_bd(g);
    localparam int PM  = cfg_par(g);
    localparam int SB  = cfg_sb(g);
    localparam int MF  = cfg_mf(g);
    localparam int BPB = 10 + ((PM != 0) ? 1 : 0) + SB - 1;
    localparam int L   = NB * BPB * BD;

    logic            rst_n, data_en;
    logic [8*NB-1:0] data_in;
    logic            ready, busy, done, tx;

    uart_tx_packet #(
      .NBYTES(NB), .BAUD_DIV(BD), .PARITY(PM), .STOP_BITS(SB), .MSB_BYTE_FIRST(MF)
    ) dut (
      .Clk(clk), .RstN(rst_n), .DataEn(data_en), .DataIn(data_in),
      .Ready(ready), .Busy(busy), .Done(done), .Tx(tx)
    );

    int   cyc = 0;
    int   idle_at = 0;
    int   epoch = 0;
    int   rst_edge = -1;
    bit   rst_seen = 1'b0;
    pkt_t pkt_q[$];
    int   done_q[$];

    // Expected line contents of one packet, one entry per bit period
    function automatic pkt_t build(input int acc, input logic [8*NB-1:0] d);
      pkt_t       p;
      logic [7:0] b;
      int         idx;
      p.acc = acc; p.nbits = 0; p.bits = '1;
      for (int j = 0; j < NB; j++) begin
        idx = (MF != 0) ? NB - 1 - j : j;
        b = d[8*idx +: 8];
        p.bits[p.nbits] = 1'b0; p.nbits++;
        for (int k = 0; k < 8; k++) begin p.bits[p.nbits] = b[k]; p.nbits++; end
        if (PM == 1) begin p.bits[p.nbits] = ($countones(b) % 2 == 0); p.nbits++; end
        if (PM == 2) begin p.bits[p.nbits] = ($countones(b) % 2 == 1); p.nbits++; end
        for (int s = 0; s < SB; s++) begin p.bits[p.nbits] = 1'b1; p.nbits++; end
      end
      return p;
    endfunction

    // Reference model: decides acceptance and when the packet should finish
    always @(posedge clk) begin
      cyc = cyc + 1;
      if (!rst_n) begin
        pkt_q.delete();
        done_q.delete();
        idle_at  = cyc;
        rst_edge = cyc;
        epoch    = epoch + 1;
        rst_seen = 1'b1;
      end else if (rst_seen && cyc > idle_at && data_en) begin
        pkt_q.push_back(build(cyc, data_in));
        done_q.push_back(cyc + L);
        idle_at = cyc + L;
      end
    end

    always @(negedge clk) begin
      logic exp_r, exp_d;
      if (rst_seen) begin
        exp_r = (cyc >= idle_at);
        exp_d = (done_q.size() > 0 && done_q[0] == cyc);
        if (exp_d) void'(done_q.pop_front());
        check(g, $sformatf("ctl{ready,busy,done}@%0d", cyc), {ready, busy, done}, {exp_r, !exp_r, exp_d});
        if (rst_edge == cyc) check(g, $sformatf("reset_tx@%0d", cyc), tx, 1'b1);
      end
    end

    // Line monitor: a falling Tx starts a packet; every sample of every bit
    // period must match, which also pins each bit to exactly BD cycles.
    initial begin : mon
      pkt_t p;
      int   ep, nbad;
      logic got, e;
      bit   ab;
      forever begin
        @(negedge clk);
        if (rst_seen && tx !== 1'b1) begin
          if (pkt_q.size() == 0) begin
            check(g, $sformatf("spurious_start@%0d", cyc), tx, 1'b1);
          end else begin
            p  = pkt_q.pop_front();
            ep = epoch;
            ab = 1'b0;
            check(g, $sformatf("start_latency_pkt@%0d", p.acc), cyc - p.acc, 1);
            for (int i = 0; i < p.nbits && !ab; i++) begin
              e = p.bits[i]; got = e; nbad = 0;
              for (int k = 0; k < BD; k++) begin
                if (i > 0 || k > 0) @(negedge clk);
                if (epoch != ep) begin ab = 1'b1; break; end
                if (tx !== e) begin if (nbad == 0) got = tx; nbad++; end
              end
              if (!ab) check(g, $sformatf("frame_bit%0d_pkt@%0d", i, p.acc), got, e);
            end
          end
        end
      end
    end

    task automatic wait_idle();
      for (int i = 0; i < L + 10; i++) begin
        if (cyc >= idle_at) return;
        @(negedge clk);
      end
      n_cmp++; n_fail++;
      $display("FAIL cfg%0d idle_wait: got busy at %0d, required idle by %0d", g, cyc, idle_at);
    endtask

    initial begin : stim
      logic [127:0] t;
      rst_n = 1'b0; data_en = 1'b0; data_in = '0;
      repeat (3) @(negedge clk);
      t = cfg_dir(g);
      rst_n = 1'b1; data_en = 1'b1; data_in = t[8*NB-1:0];
      @(negedge clk);
      data_en = 1'b0;
      t = rnd128(); data_in = t[8*NB-1:0];
      wait_idle();
      if (BD < 100) begin
        for (int i = 0; i < 400; i++) begin
          t = rnd128();
          data_en = ($urandom_range(0, 5) == 0);
          data_in = t[8*NB-1:0];
          @(negedge clk);
        end
        data_en = 1'b0;
        wait_idle();
        // Held request: exactly three acceptances inside this window
        data_en = 1'b1;
        for (int i = 0; i < 2 * L + 3; i++) begin
          t = rnd128(); data_in = t[8*NB-1:0];
          @(negedge clk);
        end
        data_en = 1'b0;
        wait_idle();
        // Abort mid-packet, then restart straight out of reset
        t = rnd128(); data_in = t[8*NB-1:0]; data_en = 1'b1;
        @(negedge clk);
        data_en = 1'b0;
        for (int i = 0; i < ((NB > 1) ? BPB * BD + 3 * BD : 3 * BD); i++) begin
          t = rnd128(); data_in = t[8*NB-1:0];
          @(negedge clk);
        end
        rst_n = 1'b0;
        @(negedge clk);
        t = rnd128();
        rst_n = 1'b1; data_en = 1'b1; data_in = t[8*NB-1:0];
        @(negedge clk);
        data_en = 1'b0;
        wait_idle();
      end
      repeat (20) @(negedge clk);
      check(g, "packets_left_unsent", pkt_q.size(), 0);
      check(g, "done_pulses_missing", done_q.size(), 0);
      blocks_done++;
    end
  end

  initial begin
    for (int i = 0; i < 60000; i++) begin
      @(posedge clk);
      if (blocks_done == NCFG) break;
    end
    if (blocks_done != NCFG) begin
      n_cmp++; n_fail++;
      $display("FAIL timeout: got %0d configs finished, required %0d", blocks_done, NCFG);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_packet.md
UART_TX_PACKET -- requirements
Module: uart_tx_packet

Interface
REQ-001 SHALL have parameter NBYTES, default 5: bytes per packet, legal range 1..16.
REQ-002 SHALL have parameter BAUD_DIV, default 5208: clock cycles per bit (50 MHz / 9600), legal range 2..8191.
REQ-003 SHALL have parameter PARITY, default 0: parity mode, 0 = none, 1 = odd, 2 = even.
REQ-004 SHALL have parameter STOP_BITS, default 1: stop bits per byte, 1 or 2.
REQ-005 SHALL have parameter MSB_BYTE_FIRST, default 1: 1 = DataIn[8*NBYTES-1 -: 8] is sent first; 0 = DataIn[7:0] is sent first.
REQ-006 SHALL have port Clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-007 SHALL have port RstN, input, 1 bit: reset, synchronous and active-low.
REQ-008 SHALL have port DataEn, input, 1 bit: packet start request, sampled only in IDLE.
REQ-009 SHALL have port DataIn, input, 8*NBYTES bits: packet payload, captured on acceptance.
REQ-010 SHALL have port Ready, output, 1 bit: high exactly when in IDLE.
REQ-011 SHALL have port Busy, output, 1 bit: high from acceptance until the last stop bit ends.
REQ-012 SHALL have port Done, output, 1 bit: one-cycle pulse on packet completion.
REQ-013 SHALL have port Tx, output, 1 bit: registered serial line, idles high.

Function
REQ-014 SHALL implement states IDLE, START, DATA, PAR, STOP. Transitions:
- IDLE->START on DataEn=1.
- START->DATA after 1 bit time.
- DATA->PAR after 8 bits when PARITY!=0; DATA->STOP after 8 bits otherwise.
- PAR->STOP after 1 bit time.
- STOP->START when more bytes remain.
- STOP->IDLE after the last byte.
REQ-015 SHALL capture DataIn into an internal shift buffer on the acceptance edge; DataIn changes after acceptance SHALL have no effect on the packet in flight.
REQ-016 SHALL drive Tx low (start bit) on the clock edge following acceptance: latency 1 cycle.
REQ-017 SHALL hold every bit (start, data, parity, each stop bit) on Tx for exactly BAUD_DIV cycles.
REQ-018 SHALL send data bits LSB first, 8 data bits per byte.
REQ-019 SHALL send a parity bit that makes the total count of ones in data plus parity odd (PARITY=1) or even (PARITY=2).
REQ-020 SHALL start the next byte's start bit immediately after the final stop bit, with no idle gap between bytes.
REQ-021 SHALL pulse Done for one cycle in the cycle Busy falls; Ready SHALL rise in that same cycle.
REQ-022 SHALL, if DataEn is high in that first IDLE cycle, accept a new packet immediately, so back-to-back packets have exactly one idle-high cycle between them.
REQ-023 SHALL ignore DataEn while Busy; requests are neither queued nor dropped with error.
REQ-024 SHALL size the baud counter to clog2(BAUD_DIV) bits, the bit counter to 3 bits, and the byte counter to clog2(NBYTES+1) bits; every counter SHALL wrap to 0 when its terminal count is reached, never by overflow.
REQ-025 SHALL count stop bits and the byte total exactly; the packet SHALL end after NBYTES bytes regardless of DataEn.

Reset
REQ-026 SHALL, on the edge where RstN=0, set state=IDLE, Tx=1, Ready=1, Busy=0, Done=0, and clear all counters and the shift buffer.
REQ-027 SHALL, on reset mid-packet, abort the packet: Tx returns high on that edge, no Done pulse is issued, and no residual bits are sent after RstN rises.
REQ-028 SHALL, when DataEn=1 in the first cycle after RstN rises, accept normally.

Structure
REQ-029 SHALL take the parity-mode constants (PAR_NONE, PAR_ODD, PAR_EVEN) and the state encoding from the shared package uart_pkg.
REQ-030 SHALL place the bit-period counter in one sub-module, uart_baud_tick (parameter BAUD_DIV; inputs Clk, RstN, clear; output tick one cycle per bit period); the rest is a single FSM.
REQ-031 SHALL reject illegal parameter values with an elaboration-time error.

Verification (BAUD_DIV=4 unless stated)
REQ-032 SHALL cover the default packet: NBYTES=5, PARITY=0, DataIn=40'h80_FF_01_AA_55 pulsed 1 cycle -> Tx bytes 80,FF,01,AA,55, 10 bits each, 200 Busy cycles, then a single Done pulse.
REQ-033 SHALL cover parity: PARITY=1, NBYTES=1, DataIn=8'h07 -> parity bit 0, frame 0,1110 0000,0,1; with PARITY=2 -> parity bit 1.
REQ-034 SHALL cover byte order and stop bits: MSB_BYTE_FIRST=0, STOP_BITS=2, DataIn=16'h1234 -> 34 sent first, then 12, each stop period high for 8 cycles.
REQ-035 SHALL cover streaming: DataEn held high for 3 packets -> exactly 1 idle cycle between packets, 3 Done pulses, and DataIn sampled only at the 3 acceptance edges.
REQ-036 SHALL cover reset mid-operation: RstN=0 during the 2nd byte's data bits -> Tx=1 and Ready=1 on the next edge, no Done pulse; a new DataEn after release sends the full packet from byte 0.
REQ-037 SHALL cover bit timing: BAUD_DIV=5208 -> Tx falls 1 cycle after acceptance and each bit lasts exactly 5208 cycles (checked by an edge-interval monitor).
